// File: rtl/othello_pkg.sv
// Shared Othello board definitions: cell codes, board geometry, direction steps
// and the directional validator state encoding.
package othello_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY  = 2'b00;
    localparam cell_t CELL_BLACK  = 2'b01;
    localparam cell_t CELL_WHITE  = 2'b10;
    localparam cell_t CELL_BORDER = 2'b11;

    localparam int BOARD_W     = 10;
    localparam int BOARD_CELLS = BOARD_W * BOARD_W;

    localparam logic signed [4:0] STEP_U = -5'sd10;
    localparam logic signed [4:0] STEP_D = 5'sd10;
    localparam logic signed [4:0] STEP_L = -5'sd1;
    localparam logic signed [4:0] STEP_R = 5'sd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EV,
        ST_WR,
        ST_DONE
    } state_e;

    function automatic cell_t opponent_of(cell_t player);
        return player ^ 2'b11;
    endfunction

endpackage

// File: rtl/dir_validator_if.sv
// Board memory bus between the direction validator (master) and the board RAM (slave).
interface dir_validator_if
    import othello_pkg::*;
#(
    parameter int ADDR_W = 7
);

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wr_o;
    cell_t             mem_wdata_o;
    cell_t             mem_rdata_i;

    modport master (
        output mem_addr_o,
        output mem_wr_o,
        output mem_wdata_o,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_wr_o,
        input  mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/dir_validator_addr_stepper.sv
// Signed board-address stepper: next = base + step, flagged out of range when the
// result falls below zero or past the last board cell.
module dir_validator_addr_stepper
    import othello_pkg::*;
#(
    parameter int CELLS = othello_pkg::BOARD_CELLS
)
(
    input  logic signed [7:0] base_i,
    input  logic signed [4:0] step_i,
    output logic signed [7:0] next_o,
    output logic              out_of_range_o
);

    localparam logic [7:0] CELLS_C = 8'(CELLS);

    logic signed [8:0] sum;

    // One guard bit keeps origin+step from wrapping for any 7-bit origin.
    always_comb begin
        sum            = {base_i[7], base_i} + {{4{step_i[4]}}, step_i};
        next_o         = sum[7:0];
        out_of_range_o = sum[8] | (sum[7:0] >= CELLS_C);
    end

endmodule

// File: rtl/dir_validator.sv
// Walks the board from a placed piece along one direction, reports whether it
// brackets opponent pieces and optionally flips them to the mover's colour.
module dir_validator
    import othello_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int BOARD_CELLS = othello_pkg::BOARD_CELLS,
    parameter int MAX_RUN     = 7
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ld,
    input  logic               enable,
    input  logic signed [4:0]  step_in,
    input  logic [ADDR_W-1:0]  origin_i,
    input  logic [1:0]         player_i,
    input  logic               flip_i,
    dir_validator_if.master    mem,
    output logic               s_done_o,
    output logic               dir_status_o,
    output logic [2:0]         flip_cnt_o,
    output logic               busy_o
);

    localparam logic [2:0] MAX_RUN_C = 3'(MAX_RUN);

    state_e             state_q, state_d;
    logic signed [7:0]  cur_q, cur_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         wr_left_q, wr_left_d;
    logic signed [4:0]  step_q, step_d;
    logic [ADDR_W-1:0]  origin_q, origin_d;
    cell_t              player_q, player_d;
    logic               flip_q, flip_d;
    logic               status_q, status_d;
    logic [2:0]         flip_cnt_q, flip_cnt_d;

    logic               idle_like;
    logic               ld_acc;
    logic               en_acc;
    logic signed [4:0]  step_eff;
    logic [ADDR_W-1:0]  origin_eff;
    cell_t              player_eff;
    logic               flip_eff;
    logic               player_ok;
    logic               rd_opp;
    logic               rd_own;
    logic               use_origin;
    logic signed [7:0]  step_base;
    logic signed [7:0]  step_next;
    logic               step_oor;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_wr;
    cell_t              mem_wdata;

    dir_validator_addr_stepper #(
        .CELLS (BOARD_CELLS)
    ) u_stepper (
        .base_i         (step_base),
        .step_i         (step_eff),
        .next_o         (step_next),
        .out_of_range_o (step_oor)
    );

    // A same-cycle ld feeds the port values straight through so the walk never
    // starts from stale latches.
    always_comb begin
        idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        ld_acc     = ld && idle_like;
        en_acc     = enable && idle_like;
        step_eff   = ld_acc ? step_in  : step_q;
        origin_eff = ld_acc ? origin_i : origin_q;
        player_eff = ld_acc ? player_i : player_q;
        flip_eff   = ld_acc ? flip_i   : flip_q;
        player_ok  = (player_eff == CELL_BLACK) || (player_eff == CELL_WHITE);
        rd_opp     = (mem.mem_rdata_i == opponent_of(player_eff));
        rd_own     = (mem.mem_rdata_i == player_eff);
        use_origin = !((state_q == ST_WR) || ((state_q == ST_EV) && rd_opp));
        step_base  = use_origin ? 8'(origin_eff) : cur_q;
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        wr_left_d  = wr_left_q;
        step_d     = step_eff;
        origin_d   = origin_eff;
        player_d   = player_eff;
        flip_d     = flip_eff;
        status_d   = status_q;
        flip_cnt_d = flip_cnt_q;
        mem_addr   = '0;
        mem_wr     = 1'b0;
        mem_wdata  = CELL_EMPTY;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (en_acc) begin
                    status_d   = 1'b0;
                    flip_cnt_d = '0;
                    cnt_d      = '0;
                    wr_left_d  = '0;
                    cur_d      = step_next;
                    state_d    = (!player_ok || step_oor) ? ST_DONE : ST_RD;
                end
            end

            ST_RD: begin
                mem_addr = cur_q[ADDR_W-1:0];
                state_d  = ST_EV;
            end

            ST_EV: begin
                state_d = ST_DONE;
                if (rd_opp && (cnt_q < MAX_RUN_C)) begin
                    cnt_d = cnt_q + 3'd1;
                    if (!step_oor) begin
                        cur_d   = step_next;
                        state_d = ST_RD;
                    end
                end else if (rd_own && (cnt_q != 3'd0)) begin
                    if (flip_q) begin
                        cur_d     = step_next;
                        wr_left_d = cnt_q;
                        state_d   = ST_WR;
                    end else begin
                        status_d   = 1'b1;
                        flip_cnt_d = cnt_q;
                    end
                end
            end

            ST_WR: begin
                mem_wr    = 1'b1;
                mem_addr  = cur_q[ADDR_W-1:0];
                mem_wdata = player_q;
                cur_d     = step_next;
                wr_left_d = wr_left_q - 3'd1;
                if (wr_left_q == 3'd1) begin
                    status_d   = 1'b1;
                    flip_cnt_d = cnt_q;
                    state_d    = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            wr_left_q  <= '0;
            step_q     <= '0;
            origin_q   <= '0;
            player_q   <= CELL_EMPTY;
            flip_q     <= 1'b0;
            status_q   <= 1'b0;
            flip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            wr_left_q  <= wr_left_d;
            step_q     <= step_d;
            origin_q   <= origin_d;
            player_q   <= player_d;
            flip_q     <= flip_d;
            status_q   <= status_d;
            flip_cnt_q <= flip_cnt_d;
        end
    end

    assign mem.mem_addr_o  = mem_addr;
    assign mem.mem_wr_o    = mem_wr;
    assign mem.mem_wdata_o = mem_wdata;

    assign s_done_o     = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign dir_status_o = status_q;
    assign flip_cnt_o   = flip_cnt_q;

endmodule

// File: tb/tb_dir_validator.sv
// Scoreboard bench for dir_validator: directed walks push expected results, a
// monitor pops them on each s_done_o; a behavioural board RAM answers the bus.
module tb_dir_validator;
    import othello_pkg::*;

    typedef struct {
        logic       status;
        logic [2:0] cnt;
        int         done_cyc;
        int         writes;
        string      name;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              ld;
    logic              enable;
    logic signed [4:0] step_in;
    logic [6:0]        origin_i;
    logic [1:0]        player_i;
    logic              flip_i;
    logic              s_done_o;
    logic              dir_status_o;
    logic [2:0]        flip_cnt_o;
    logic              busy_o;

    cell_t board [0:127];
    exp_t  sb [$];
    int    cyc   = 0;
    int    tests = 0;
    int    fails = 0;

    dir_validator_if #(.ADDR_W(7)) mem_bus ();

    dir_validator #(
        .ADDR_W      (7),
        .BOARD_CELLS (100),
        .MAX_RUN     (7)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ld           (ld),
        .enable       (enable),
        .step_in      (step_in),
        .origin_i     (origin_i),
        .player_i     (player_i),
        .flip_i       (flip_i),
        .mem          (mem_bus.master),
        .s_done_o     (s_done_o),
        .dir_status_o (dir_status_o),
        .flip_cnt_o   (flip_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic initBoard();
        for (int i = 0; i < 128; i++) board[i] = CELL_BORDER;
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++) board[r * 10 + c] = CELL_EMPTY;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        #1;
        if (sb.size() != 0) begin
            checkOutput({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [6:0] origin, input logic signed [4:0] step,
                                 input logic [1:0] player, input logic flip,
                                 input logic exp_status, input logic [2:0] exp_cnt,
                                 input int latency, input int exp_wr, input string name);
        exp_t e;
        @(negedge clock);
        ld       = 1'b1;
        enable   = 1'b1;
        origin_i = origin;
        step_in  = step;
        player_i = player;
        flip_i   = flip;
        e.status   = exp_status;
        e.cnt      = exp_cnt;
        e.done_cyc = cyc + latency;
        e.writes   = exp_wr;
        e.name     = name;
        sb.push_back(e);
        @(negedge clock);
        ld     = 1'b0;
        enable = 1'b0;
        waitDrain(name);
    endtask

    initial begin
        reset    = 1'b0;
        ld       = 1'b0;
        enable   = 1'b0;
        step_in  = '0;
        origin_i = '0;
        player_i = '0;
        flip_i   = 1'b0;
        mem_bus.mem_rdata_i = CELL_EMPTY;
        initBoard();

        fork
            begin : mem_model
                logic [6:0] a;
                logic       w;
                cell_t      d;
                forever begin
                    @(negedge clock);
                    a = mem_bus.mem_addr_o;
                    w = mem_bus.mem_wr_o;
                    d = mem_bus.mem_wdata_o;
                    @(posedge clock);
                    cyc++;
                    if (w) board[a] = d;
                    mem_bus.mem_rdata_i <= board[a];
                end
            end
            begin : monitor
                exp_t e;
                int   wr_seen;
                wr_seen = 0;
                forever begin
                    @(negedge clock);
                    if (!reset) begin
                        wr_seen = 0;
                    end else begin
                        if (mem_bus.mem_wr_o) wr_seen++;
                        if (s_done_o) begin
                            if (sb.size() == 0) begin
                                checkOutput("unexpected_done", 1, 0);
                            end else begin
                                e = sb.pop_front();
                                checkOutput({e.name, "_status"}, int'(dir_status_o), int'(e.status));
                                checkOutput({e.name, "_cnt"}, int'(flip_cnt_o), int'(e.cnt));
                                checkOutput({e.name, "_done_cycle"}, cyc, e.done_cyc);
                                checkOutput({e.name, "_writes"}, wr_seen, e.writes);
                            end
                            wr_seen = 0;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clock);
        #1;
        checkOutput("rst_s_done", int'(s_done_o), 0);
        checkOutput("rst_status", int'(dir_status_o), 0);
        checkOutput("rst_cnt", int'(flip_cnt_o), 0);
        checkOutput("rst_busy", int'(busy_o), 0);
        checkOutput("rst_addr", int'(mem_bus.mem_addr_o), 0);
        checkOutput("rst_wr", int'(mem_bus.mem_wr_o), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] black +1 bracket, no flip");
        initBoard();
        board[45] = CELL_WHITE; board[46] = CELL_WHITE; board[47] = CELL_BLACK;
        applyStimulus(7'd44, STEP_R, CELL_BLACK, 1'b0, 1'b1, 3'd2, 7, 0, "e_noflip");
        checkOutput("held_status", int'(dir_status_o), 1);
        checkOutput("held_cnt", int'(flip_cnt_o), 2);
        checkOutput("held_busy", int'(busy_o), 0);
        checkOutput("noflip_cell45", int'(board[45]), int'(CELL_WHITE));

        $display("[TB] black +1 bracket, flip");
        applyStimulus(7'd44, STEP_R, CELL_BLACK, 1'b1, 1'b1, 3'd2, 9, 2, "e_flip");
        checkOutput("flip_cell45", int'(board[45]), int'(CELL_BLACK));
        checkOutput("flip_cell46", int'(board[46]), int'(CELL_BLACK));
        checkOutput("flip_cell47", int'(board[47]), int'(CELL_BLACK));

        $display("[TB] short and border cases");
        initBoard();
        applyStimulus(7'd44, STEP_U, CELL_BLACK, 1'b0, 1'b0, 3'd0, 3, 0, "up_empty");
        applyStimulus(7'd11, STEP_U, CELL_BLACK, 1'b0, 1'b0, 3'd0, 3, 0, "up_border");
        applyStimulus(7'd5, STEP_U, CELL_BLACK, 1'b0, 1'b0, 3'd0, 1, 0, "up_oor");
        applyStimulus(7'd44, STEP_R, 2'b00, 1'b0, 1'b0, 3'd0, 1, 0, "bad_player");
        board[45] = CELL_BLACK;
        applyStimulus(7'd44, STEP_R, CELL_BLACK, 1'b1, 1'b0, 3'd0, 3, 0, "own_adjacent");

        $display("[TB] run into border ring");
        initBoard();
        board[46] = CELL_WHITE; board[47] = CELL_WHITE; board[48] = CELL_WHITE;
        applyStimulus(7'd45, STEP_R, CELL_BLACK, 1'b1, 1'b0, 3'd0, 9, 0, "run_border");

        $display("[TB] white +10 flip");
        initBoard();
        board[54] = CELL_BLACK; board[64] = CELL_BLACK; board[74] = CELL_WHITE;
        applyStimulus(7'd44, STEP_D, CELL_WHITE, 1'b1, 1'b1, 3'd2, 9, 2, "white_down");
        checkOutput("white_cell54", int'(board[54]), int'(CELL_WHITE));
        checkOutput("white_cell64", int'(board[64]), int'(CELL_WHITE));

        $display("[TB] reset during write phase");
        initBoard();
        board[45] = CELL_WHITE; board[46] = CELL_WHITE; board[47] = CELL_BLACK;
        @(negedge clock);
        ld = 1'b1; enable = 1'b1;
        origin_i = 7'd44; step_in = STEP_R; player_i = CELL_BLACK; flip_i = 1'b1;
        @(negedge clock);
        ld = 1'b0; enable = 1'b0;
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                if (mem_bus.mem_wr_o) break;
                @(negedge clock);
            end
            checkOutput("first_write_seen", int'(k < 20), 1);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checkOutput("mid_rst_wr", int'(mem_bus.mem_wr_o), 0);
        checkOutput("mid_rst_addr", int'(mem_bus.mem_addr_o), 0);
        checkOutput("mid_rst_busy", int'(busy_o), 0);
        checkOutput("mid_rst_done", int'(s_done_o), 0);
        checkOutput("mid_rst_status", int'(dir_status_o), 0);
        checkOutput("mid_rst_cnt", int'(flip_cnt_o), 0);
        repeat (2) @(negedge clock);
        checkOutput("mid_rst_cell45", int'(board[45]), int'(CELL_BLACK));
        checkOutput("mid_rst_cell46", int'(board[46]), int'(CELL_WHITE));
        reset = 1'b1;
        repeat (2) @(negedge clock);
        initBoard();
        board[45] = CELL_WHITE; board[46] = CELL_WHITE; board[47] = CELL_BLACK;
        applyStimulus(7'd44, STEP_R, CELL_BLACK, 1'b0, 1'b1, 3'd2, 7, 0, "after_rst");

        $display("[TB] ld+enable bypass and enables while busy");
        initBoard();
        board[43] = CELL_WHITE; board[42] = CELL_BLACK;
        @(negedge clock);
        ld = 1'b1; origin_i = 7'd44; step_in = STEP_R; player_i = CELL_BLACK; flip_i = 1'b0;
        @(negedge clock);
        ld = 1'b0;
        @(negedge clock);
        ld = 1'b1; enable = 1'b1; step_in = STEP_L;
        begin
            exp_t e;
            e.status = 1'b1; e.cnt = 3'd1; e.done_cyc = cyc + 5; e.writes = 0; e.name = "bypass";
            sb.push_back(e);
        end
        @(negedge clock);
        ld = 1'b0; enable = 1'b0;
        step_in = STEP_R;
        @(negedge clock);
        checkOutput("busy_mid_walk", int'(busy_o), 1);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        waitDrain("bypass");
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dir_validator.md
Name: dir_validator

Overview:
- Directional move checker driven by the new-move controller.
- Given a placed-piece address, a direction step and the moving player, it walks the board memory along that direction. It reports whether the direction brackets at least one opponent piece, and optionally flips the bracketed pieces.
- Each call covers one direction. The controller issues four calls per move (steps -10, +10, -1, +1).
- Board is 10x10 cells, addresses 0..99, with a border ring. The 8x8 play area is rows/cols 1..8.

Parameters:
- ADDR_W, 7, board address width.
- BOARD_CELLS, 100, number of addressable cells; addresses >= BOARD_CELLS are treated as border.
- MAX_RUN, 7, maximum opponent run counted before forcing invalid.

Ports:
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low reset.
- ld  in  1  latch step_in, origin_i, player_i, flip_i.
- enable  in  1  start a walk (single-cycle pulse).
- step_in  in  5  signed two's-complement direction step (-10, +10, -1, +1 used).
- origin_i  in  ADDR_W  address of the placed piece.
- player_i  in  2  moving player colour (01 black, 10 white).
- flip_i  in  1  1 = write player colour over bracketed pieces when the direction is valid.
- mem_addr_o  out  ADDR_W  board memory address.
- mem_wr_o  out  1  board memory write strobe.
- mem_wdata_o  out  2  board memory write data.
- mem_rdata_i  in  2  board read data, valid one cycle after mem_addr_o (synchronous RAM). Codes: 00 empty, 01 black, 10 white, 11 border.
- s_done_o  out  1  one-cycle pulse at end of walk.
- dir_status_o  out  1  direction valid; held from s_done_o until next accepted enable.
- flip_cnt_o  out  3  opponent pieces bracketed (and flipped if flip_i); held like dir_status_o.
- busy_o  out  1  high from accepted enable through the s_done_o cycle.

Behaviour:
- Reset, asynchronous, any state: state goes to IDLE. All outputs are 0, including mem_addr_o, mem_wr_o, s_done_o, dir_status_o, flip_cnt_o and busy_o. Latched registers are cleared. A reset mid-walk or mid-flip stops writes immediately; there is no partial-completion guarantee.
- ld is accepted only in IDLE and DONE. enable is accepted only in IDLE and DONE; both are ignored while busy.
- If ld and enable arrive in the same cycle, the walk uses the port values of that cycle (bypass), not stale latches.
- Opponent = player XOR 2'b11. Player 00 or 11 is illegal: the walk finishes as invalid with no reads.
- cur register: 8-bit signed intermediate. cur = origin + step on start; cur += step on advance. A result < 0 or >= BOARD_CELLS is treated as border, without a read.
- States:
  - IDLE: wait for enable.
  - RD: drive mem_addr_o=cur.
  - EV: sample mem_rdata_i.
    - Data = opponent and cnt < MAX_RUN: cnt++, advance cur, go to RD.
    - Data = player and cnt >= 1: valid. Go to WR if flip_i, else DONE.
    - Otherwise (empty, border, player with cnt=0, or cnt hits MAX_RUN): invalid, go to DONE.
  - WR: cur is reset to origin+step. For each of cnt cycles: mem_wr_o=1, mem_addr_o=cur, mem_wdata_o=player, then cur += step. Then go to DONE.
  - DONE: s_done_o=1 for one cycle, dir_status_o and flip_cnt_o update (cnt for valid, 0 for invalid), then go to IDLE. An enable in DONE starts a new walk directly (goes to RD next cycle).
- Timing: enable sampled at cycle T. RD at T+1, EV at T+2, repeating. With n reads and k writes, s_done_o is at T+2n+1+k. Examples:
  - Valid with k opponents, no flip: n = k+1.
  - Out-of-range first address: n = 0, s_done_o at T+1.
- mem_wr_o is never asserted outside WR. A read and a write are never issued in the same cycle.

Decomposition:
- Shared package othello_pkg holds:
  - Cell codes CELL_EMPTY, CELL_BLACK, CELL_WHITE, CELL_BORDER.
  - BOARD_W=10 and BOARD_CELLS.
  - Step constants STEP_U=-10, STEP_D=10, STEP_L=-1, STEP_R=1.
  - The state enum.
- One sub-module is natural: addr_stepper. It handles signed add of cur+step and the range check, producing next address plus an out_of_range flag.

Test Plan:
- Origin 44, step +1, player black. Cells 45=W, 46=W, 47=B, flip=0 → dir_status_o=1, flip_cnt_o=2, s_done_o at T+7, no writes.
- Same board with flip=1 → writes B to 45 then 46 on consecutive cycles. s_done_o at T+9, and memory then reads 45=B, 46=B.
- Origin 44, step -10, cell 34 empty → dir_status_o=0, flip_cnt_o=0, s_done_o at T+3.
- Origin 11, step -10 → cur=1 is border; also origin 5, step -10 → out of range, s_done_o at T+1 with no read. Both give dir_status_o=0.
- Reset asserted (low) during WR after the first write → outputs 0 immediately, second cell is not written. After release, enable starts cleanly.
- ld+enable in the same cycle with step -1 while the latches hold +1 → walk uses -1. enable pulses while busy_o=1 are ignored, giving exactly one s_done_o.
